c2c_master_arbiter: RTL
=======================

// Module: c2c_master_arbiter
// PURPOSE
//  Master-side link controller for the chip2chip request/ack/valid link.
//  Shares the single outgoing link between NUM_REQ local requesters using
//  round-robin arbitration.
//  Sequences each transfer: raise request, wait for the slave's ack, drive
//  data with valid, then return the link to idle.
//  Supervises the slave's ack with a timeout so a missing slave never hangs
//  a requester.
// PARAMETERS
//  NUM_REQ      4          number of local requesters (2..8)
//  DATA_W       3          link data width
//  VALID_HOLD   4          cycles link_valid/link_data are held (>=1)
//  ACK_TIMEOUT  200000000  cycles to wait for ack before aborting (>=2)
// PORTS
//  clk          in   1               single clock; all logic on posedge clk
//  rst          in   1               asynchronous, active-high reset
//  req          in   NUM_REQ         level request per requester
//  req_data     in   NUM_REQ*DATA_W  requester i data at [i*DATA_W +: DATA_W]
//  grant        out  NUM_REQ         one-hot; requester currently being served
//  done         out  NUM_REQ         1-cycle pulse: transfer completed
//  err          out  NUM_REQ         1-cycle pulse: transfer aborted on timeout
//  busy         out  1               high whenever state != IDLE
//  link_request out  1               request to slave
//  link_ack     in   1               ack from slave; async, 2-FF synced inside (ack_s)
//  link_data    out  DATA_W          data to slave
//  link_valid   out  1               data-valid strobe to slave
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, rr_last=NUM_REQ-1, sync FFs=0, counters=0.
//    All outputs 0. Reset asserted mid-transfer clears outputs immediately.
//  - All outputs are registered.
//  - IDLE: if any req, pick the first set bit scanning rr_last+1, rr_last+2, ...
//    (wrapping). Latch winner index and its req_data. Set grant, link_request=1,
//    rr_last=winner, go to REQ. If no req, stay in IDLE.
//    Grant/link_request appear 1 cycle after req is sampled.
//  - REQ: link_request=1. Timeout counter increments every cycle.
//    - If ack_s=1: go to SEND; link_request=0, link_valid=1,
//      link_data=latched data.
//    - Else if counter==ACK_TIMEOUT-1: go to IDLE; err[winner] pulses for 1 cycle;
//      grant=0, link_request=0.
//    - Ack takes precedence when ack_s=1 on the timeout cycle.
//  - SEND: link_valid=1 for exactly VALID_HOLD cycles, link_data stable.
//    Then link_valid=0, link_data=0, go to RELEASE.
//  - RELEASE: wait until ack_s=0, then go to IDLE. done[winner] pulses for 1 cycle
//    on the same edge, and grant clears on that edge. This guarantees the slave's
//    ack is low before any new request is raised.
//  - Minimum gap: IDLE occupies at least 1 cycle between transfers, so
//    link_request is low for at least 1 cycle between transfers.
//  - A requester dropping req after grant does not abort the transfer; the
//    latched data is still sent. req/req_data changes during a transfer are
//    ignored.
//  - A requester holding req continuously is re-served only after every other
//    active requester has been served once (round-robin fairness).
//  - Outputs outside state meaning: grant is zero in IDLE; done and err are never
//    asserted together; at most one bit of grant, done or err is set at a time.
//  - Counter widths use $clog2 of ACK_TIMEOUT and VALID_HOLD; no wrap-around
//    occurs inside a single state.
// TESTING (NUM_REQ=4, VALID_HOLD=4, ACK_TIMEOUT=16)
//  1. rst pulse during SEND -> all outputs 0 that cycle; IDLE after release;
//     next grant goes to req0.
//  2. req=0001, data0=3'b101; ack raised 3 cycles after link_request, held
//     2 cycles -> link_valid high 4 cycles with link_data=101; done=0001 pulse;
//     busy returns to 0.
//  3. req=1111 held high, slave auto-acks -> grants in order 0001,0010,0100,
//     1000,0001.
//  4. req=0100, ack never raised -> link_request high 16 cycles;
//     err=0100 pulse; link_valid never asserted.
//  5. ack_s rises on the timeout cycle -> SEND taken, no err, done pulses.
//  6. req0 dropped 1 cycle after grant, data changed -> original latched data
//     sent; done=0001.

Source files
------------

// File: rtl/c2c_master_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : c2c_master_arbiter_if
// Brief    : chip2chip request/ack/valid link bundle (master and slave views)
// Revision : 1.0
// ============================================================================
interface c2c_master_arbiter_if #(
    parameter int DATA_W = 3
);
    logic              link_request;
    logic              link_ack;
    logic [DATA_W-1:0] link_data;
    logic              link_valid;

    modport master (
        output link_request,
        output link_data,
        output link_valid,
        input  link_ack
    );

    modport slave (
        input  link_request,
        input  link_data,
        input  link_valid,
        output link_ack
    );
endinterface
`default_nettype wire

// File: rtl/c2c_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : c2c_master_arbiter
// Brief    : round-robin master-side controller for the chip2chip link
// Revision : 1.0
// ============================================================================
module c2c_master_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 3,
    parameter int VALID_HOLD  = 4,
    parameter int ACK_TIMEOUT = 200000000
) (
    input  wire logic                        clk,
    input  wire logic                        rst,
    input  wire logic [NUM_REQ-1:0]          req,
    input  wire logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic      [NUM_REQ-1:0]          grant,
    output logic      [NUM_REQ-1:0]          done,
    output logic      [NUM_REQ-1:0]          err,
    output logic                             busy,
    c2c_master_arbiter_if.master             link
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_CNT_A = $clog2(ACK_TIMEOUT);
    localparam int c_CNT_V = $clog2(VALID_HOLD);
    localparam int c_CNT_W = (c_CNT_A > c_CNT_V) ? ((c_CNT_A > 1) ? c_CNT_A : 1)
                                                 : ((c_CNT_V > 1) ? c_CNT_V : 1);

    localparam logic [c_CNT_W-1:0] c_TO_LAST   = c_CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(VALID_HOLD - 1);

    localparam logic [1:0] c_IDLE    = 2'd0;
    localparam logic [1:0] c_REQ     = 2'd1;
    localparam logic [1:0] c_SEND    = 2'd2;
    localparam logic [1:0] c_RELEASE = 2'd3;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic                r_ack_meta;
    logic                r_ack_s;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [c_IDX_W-1:0]  r_rr_last;
    logic [c_IDX_W-1:0]  r_winner;
    logic [DATA_W-1:0]   r_data;

    logic [NUM_REQ-1:0]  r_grant, r_done, r_err;
    logic                r_busy, r_link_request, r_link_valid;
    logic [DATA_W-1:0]   r_link_data;

    logic [NUM_REQ-1:0]  w_grant_nxt, w_done_nxt, w_err_nxt;
    logic                w_link_request_nxt, w_link_valid_nxt;
    logic [DATA_W-1:0]   w_link_data_nxt;

    logic                w_any;
    logic [c_IDX_W-1:0]  w_win;
    logic [DATA_W-1:0]   w_win_data;
    logic [NUM_REQ-1:0]  w_win_onehot;
    logic [NUM_REQ-1:0]  w_cur_onehot;
    logic                w_to_hit;
    logic                w_hold_hit;

    assign grant             = r_grant;
    assign done              = r_done;
    assign err               = r_err;
    assign busy              = r_busy;
    assign link.link_request = r_link_request;
    assign link.link_valid   = r_link_valid;
    assign link.link_data    = r_link_data;

    assign w_to_hit     = (r_cnt == c_TO_LAST);
    assign w_hold_hit   = (r_cnt == c_HOLD_LAST);
    assign w_win_onehot = NUM_REQ'(1) << w_win;
    assign w_cur_onehot = NUM_REQ'(1) << r_winner;

    // Scan from the requester after the last winner, wrapping once around.
    always_comb begin
        int w_idx;
        w_idx      = 0;
        w_any      = 1'b0;
        w_win      = r_rr_last;
        w_win_data = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_idx = int'(r_rr_last) + i;
            if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
            if (!w_any && req[w_idx]) begin
                w_any = 1'b1;
                w_win = c_IDX_W'(w_idx);
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_win == c_IDX_W'(i)) w_win_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= link.link_ack;
            r_ack_s    <= r_ack_meta;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= c_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Ack wins over the timeout when both occur on the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:    if (w_any) w_state_nxt = c_REQ;
            c_REQ: begin
                if (r_ack_s)       w_state_nxt = c_SEND;
                else if (w_to_hit) w_state_nxt = c_IDLE;
            end
            c_SEND:    if (w_hold_hit) w_state_nxt = c_RELEASE;
            c_RELEASE: if (!r_ack_s)   w_state_nxt = c_IDLE;
            default:   w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_grant_nxt        = r_grant;
        w_done_nxt         = '0;
        w_err_nxt          = '0;
        w_link_request_nxt = r_link_request;
        w_link_valid_nxt   = r_link_valid;
        w_link_data_nxt    = r_link_data;
        case (r_state)
            c_IDLE: begin
                w_grant_nxt        = w_any ? w_win_onehot : '0;
                w_link_request_nxt = w_any;
            end
            c_REQ: begin
                if (r_ack_s) begin
                    w_link_request_nxt = 1'b0;
                    w_link_valid_nxt   = 1'b1;
                    w_link_data_nxt    = r_data;
                end else if (w_to_hit) begin
                    w_err_nxt          = w_cur_onehot;
                    w_grant_nxt        = '0;
                    w_link_request_nxt = 1'b0;
                end
            end
            c_SEND: begin
                if (w_hold_hit) begin
                    w_link_valid_nxt = 1'b0;
                    w_link_data_nxt  = '0;
                end
            end
            c_RELEASE: begin
                if (!r_ack_s) begin
                    w_done_nxt  = w_cur_onehot;
                    w_grant_nxt = '0;
                end
            end
            default: begin
                w_grant_nxt        = '0;
                w_link_request_nxt = 1'b0;
                w_link_valid_nxt   = 1'b0;
                w_link_data_nxt    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant        <= '0;
            r_done         <= '0;
            r_err          <= '0;
            r_busy         <= 1'b0;
            r_link_request <= 1'b0;
            r_link_valid   <= 1'b0;
            r_link_data    <= '0;
            r_cnt          <= '0;
            r_rr_last      <= c_IDX_W'(NUM_REQ - 1);
            r_winner       <= '0;
            r_data         <= '0;
        end else begin
            r_grant        <= w_grant_nxt;
            r_done         <= w_done_nxt;
            r_err          <= w_err_nxt;
            r_busy         <= (w_state_nxt != c_IDLE);
            r_link_request <= w_link_request_nxt;
            r_link_valid   <= w_link_valid_nxt;
            r_link_data    <= w_link_data_nxt;
            // Counter only runs while staying in a timed state, so it never wraps.
            if ((w_state_nxt == r_state) && ((r_state == c_REQ) || (r_state == c_SEND)))
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            if ((r_state == c_IDLE) && w_any) begin
                r_winner  <= w_win;
                r_rr_last <= w_win;
                r_data    <= w_win_data;
            end
        end
    end

endmodule
`default_nettype wire
